// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  localparam logic [15:0] NOP    = 16'h0000;
  localparam logic [15:0] PC_INC = 16'h0002;

  // Wide enough to hold a count of 0..4 entries.
  localparam int unsigned CNT_W = 3;

  function automatic logic [15:0] pc_incr(input logic [15:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch buffer with synchronous flush; flush wins over push and pop.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    push_ok = push && (cnt_q != FULL_CNT);
    pop_ok  = pop && (cnt_q != '0);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = wdata;
        wptr_d        = ptr_next(wptr_q);
      end
      if (pop_ok) begin
        rptr_d = ptr_next(rptr_q);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: it is only observed through a nonzero count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rptr_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding memory requester feeding a prefetch FIFO.
// Optional FETCH_PERF_EN adds saturating fetch/redirect counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic [15:0] new_pc,
  input  logic        jump,
  input  logic        stall,
  output logic [15:0] pc_out,
  output logic [15:0] ir_out,
  output logic [15:0] pcp2_out,
  output logic        valid_out
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_redirects
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  fetch_state_e     state_q, state_d;
  logic [15:0]      fpc_q, fpc_d;
  logic [15:0]      addr_q, addr_d;
  logic             redirect, push, pop;
  logic [CNT_W-1:0] fifo_cnt, cnt_after;
  logic             fifo_empty;
  logic [31:0]      fifo_rdata;
  logic [15:0]      pc_sel;

  assign redirect  = ~jump;
  assign valid_out = ~fifo_empty;
  assign pop       = valid_out & ~stall & jump;
  assign push      = (state_q == StWait) & imem_ack & jump;
  assign cnt_after = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

  fetch_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .flush(redirect),
    .push (push),
    .wdata({addr_q, imem_rdata}),
    .pop  (pop),
    .rdata(fifo_rdata),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    if (redirect) begin
      fpc_d = new_pc;
    end
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          state_d = StWait;
          addr_d  = new_pc;
        end else if (fifo_cnt < DEPTH_CNT) begin
          state_d = StWait;
          addr_d  = fpc_q;
        end
      end
      StWait: begin
        if (redirect) begin
          // A response landing with the redirect is stale; restart at the target.
          if (imem_ack) begin
            addr_d = new_pc;
          end else begin
            state_d = StDrop;
          end
        end else if (imem_ack) begin
          fpc_d = pc_incr(addr_q);
          if (cnt_after < DEPTH_CNT) begin
            addr_d = pc_incr(addr_q);
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDrop: begin
        if (imem_ack) begin
          state_d = StWait;
          addr_d  = redirect ? new_pc : fpc_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
    end
  end

  assign imem_req  = (state_q != StIdle);
  assign imem_addr = addr_q;
  assign pc_sel    = valid_out ? fifo_rdata[31:16] : fpc_q;
  assign pc_out    = pc_sel;
  assign pcp2_out  = pc_incr(pc_sel);
  assign ir_out    = valid_out ? fifo_rdata[15:0] : NOP;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_redirects_q, perf_redirects_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q;
    perf_redirects_d = perf_redirects_q;
    if (push && (perf_fetched_q != 16'hFFFF)) begin
      perf_fetched_d = perf_fetched_q + 16'd1;
    end
    if (redirect && (perf_redirects_q != 16'hFFFF)) begin
      perf_redirects_d = perf_redirects_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall back-pressure, redirects, wrap and reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] new_pc;
  logic        jump;
  logic        stall;
  logic [15:0] pc_out, ir_out, pcp2_out;
  logic        valid_out;
  logic        beef;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_redirects;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Memory model: returns a word derived from the address, or a poison word.
  assign imem_rdata = beef ? 16'hBEEF : mem(imem_addr);

  fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .new_pc    (new_pc),
    .jump      (jump),
    .stall     (stall),
    .pc_out    (pc_out),
    .ir_out    (ir_out),
    .pcp2_out  (pcp2_out),
    .valid_out (valid_out)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_redirects(perf_redirects)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'h0);
    check({tag, "_addr"}, 32'(imem_addr), 32'h0000);
    check({tag, "_valid"}, 32'(valid_out), 32'h0);
    check({tag, "_ir"}, 32'(ir_out), 32'h0000);
    check({tag, "_pc"}, 32'(pc_out), 32'h0000);
    check({tag, "_pcp2"}, 32'(pcp2_out), 32'h0002);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; jump = 1'b1; stall = 1'b0; new_pc = '0; beef = 1'b0;
    #2;
    check_reset_outputs("rst");
    step(); step();
    reset = 1'b0; imem_ack = 1'b1;

    // Streaming from reset with ack tied high.
    step();
    check("s1_addr", 32'(imem_addr), 32'h0000);
    check("s1_req", 32'(imem_req), 32'h1);
    check("s1_valid", 32'(valid_out), 32'h0);
    step();
    check("s2_addr", 32'(imem_addr), 32'h0002);
    check("s2_valid", 32'(valid_out), 32'h1);
    check("s2_pc", 32'(pc_out), 32'h0000);
    check("s2_ir", 32'(ir_out), 32'(mem(16'h0000)));
    check("s2_pcp2", 32'(pcp2_out), 32'h0002);
    step();
    check("s3_addr", 32'(imem_addr), 32'h0004);
    check("s3_pc", 32'(pc_out), 32'h0002);
    check("s3_ir", 32'(ir_out), 32'(mem(16'h0002)));

    // Stall: FIFO fills, request drops, head held.
    stall = 1'b1;
    step();
    check("st_req", 32'(imem_req), 32'h0);
    check("st_valid", 32'(valid_out), 32'h1);
    check("st_pc", 32'(pc_out), 32'h0002);
    for (int i = 0; i < 4; i++) begin
      step();
      check("st_hold_req", 32'(imem_req), 32'h0);
      check("st_hold_pc", 32'(pc_out), 32'h0002);
    end
    stall = 1'b0;
    step();
    check("un1_pc", 32'(pc_out), 32'h0004);
    check("un1_ir", 32'(ir_out), 32'(mem(16'h0004)));
    check("un1_req", 32'(imem_req), 32'h0);
    step();
    check("un2_valid", 32'(valid_out), 32'h0);
    check("un2_pc", 32'(pc_out), 32'h0006);
    check("un2_req", 32'(imem_req), 32'h1);
    check("un2_addr", 32'(imem_addr), 32'h0006);
    step();
    check("un3_pc", 32'(pc_out), 32'h0006);
    check("un3_valid", 32'(valid_out), 32'h1);
    check("un3_addr", 32'(imem_addr), 32'h0008);

    // Redirect while waiting, ack delayed: response dropped, then fetch target.
    imem_ack = 1'b0; jump = 1'b0; new_pc = 16'h0040;
    step();
    jump = 1'b1;
    check("dr_valid", 32'(valid_out), 32'h0);
    check("dr_pc", 32'(pc_out), 32'h0040);
    check("dr_req", 32'(imem_req), 32'h1);
    check("dr_addr", 32'(imem_addr), 32'h0008);
    for (int i = 0; i < 2; i++) begin
      step();
      check("dr_hold_req", 32'(imem_req), 32'h1);
      check("dr_hold_addr", 32'(imem_addr), 32'h0008);
      check("dr_hold_valid", 32'(valid_out), 32'h0);
    end
    imem_ack = 1'b1;
    step();
    check("dr_ack_addr", 32'(imem_addr), 32'h0040);
    check("dr_ack_valid", 32'(valid_out), 32'h0);
    step();
    check("dr_fetch_valid", 32'(valid_out), 32'h1);
    check("dr_fetch_pc", 32'(pc_out), 32'h0040);
    check("dr_fetch_ir", 32'(ir_out), 32'(mem(16'h0040)));
    check("dr_fetch_addr", 32'(imem_addr), 32'h0042);

    // Redirect coinciding with ack of a poison word.
    jump = 1'b0; new_pc = 16'h0100; beef = 1'b1;
    check("bf_pre_ir", 32'(ir_out), 32'(mem(16'h0040)));
    step();
    jump = 1'b1; beef = 1'b0;
    check("bf_addr", 32'(imem_addr), 32'h0100);
    check("bf_valid", 32'(valid_out), 32'h0);
    check("bf_ir", 32'(ir_out), 32'h0000);
    step();
    check("bf_next_ir", 32'(ir_out), 32'(mem(16'h0100)));
    check("bf_next_pc", 32'(pc_out), 32'h0100);

    // Address wrap at 0xFFFE.
    jump = 1'b0; new_pc = 16'hFFFE;
    step();
    jump = 1'b1;
    check("wr_addr", 32'(imem_addr), 32'hFFFE);
    check("wr_valid", 32'(valid_out), 32'h0);
    check("wr_fpc", 32'(pc_out), 32'hFFFE);
    check("wr_fpcp2", 32'(pcp2_out), 32'h0000);
    step();
    check("wr_pc", 32'(pc_out), 32'hFFFE);
    check("wr_pcp2", 32'(pcp2_out), 32'h0000);
    check("wr_next_addr", 32'(imem_addr), 32'h0000);
    step();
    check("wr2_pc", 32'(pc_out), 32'h0000);
    check("wr2_addr", 32'(imem_addr), 32'h0002);

    // Asynchronous reset in the middle of a transfer.
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("arst");
    step();
    check("arst_edge_req", 32'(imem_req), 32'h0);
    reset = 1'b0;
    step();
    check("post_valid", 32'(valid_out), 32'h0);
    check("post_addr", 32'(imem_addr), 32'h0000);
    check("post_req", 32'(imem_req), 32'h1);
    step();
    check("post2_valid", 32'(valid_out), 32'h1);
    check("post2_pc", 32'(pc_out), 32'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, number of prefetch buffer entries (legal 2..4).
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req  out  1  instruction-memory request, held until acknowledged.
REQ-006 SHALL have port imem_addr  out  16  fetch address, stable while imem_req=1.
REQ-007 SHALL have port imem_ack  in  1  response valid; a transfer completes when imem_req=1 and imem_ack=1 on the same edge.
REQ-008 SHALL have port imem_rdata  in  16  instruction word, valid with imem_ack.
REQ-009 SHALL have port new_pc  in  16  redirect target from decode.
REQ-010 SHALL have port jump  in  1  active-low redirect: 0 = redirect to new_pc this cycle.
REQ-011 SHALL have port stall  in  1  downstream hold: 1 = head entry not consumed.
REQ-012 SHALL have ports pc_out, ir_out, pcp2_out  out  16 each  head entry PC, instruction, and PC+2.
REQ-013 SHALL have port valid_out  out  1  head entry valid.

Function
REQ-014 SHALL have an internal fetch PC (fpc) and an FSM with states IDLE (no request outstanding), WAIT (request outstanding, response kept) and DROP (request outstanding, response discarded).
REQ-015 SHALL assert imem_req=1 in WAIT and DROP only; imem_addr SHALL be registered and change only on entry to WAIT.
REQ-016 In IDLE with a free FIFO slot and no redirect: SHALL enter WAIT with imem_addr=fpc.
REQ-017 WAIT with ack and no redirect: SHALL push {imem_addr, imem_rdata}, set fpc=imem_addr+2 (16-bit wrap, 16'hFFFE+2=16'h0000), re-enter WAIT with the new address if a slot remains after push/pop, else go to IDLE.
REQ-018 SHALL sustain one instruction per cycle when imem_ack is continuously high and stall=0.
REQ-019 Redirect (jump=0): SHALL flush the FIFO and set fpc=new_pc at that edge; valid_out=0 from the next cycle.
REQ-020 Redirect while IDLE: SHALL enter WAIT with imem_addr=new_pc on the next cycle.
REQ-021 Redirect while WAIT without ack: SHALL enter DROP; redirect with ack on the same edge: SHALL discard the data and enter WAIT with imem_addr=new_pc.
REQ-022 DROP on ack: SHALL discard the data, push nothing, and go to WAIT with imem_addr=fpc; a further redirect in DROP SHALL only update fpc.
REQ-023 Outputs SHALL be combinational from the FIFO head; pcp2_out=pc_out+2; when valid_out=0: ir_out=16'h0000, pc_out=fpc, pcp2_out=fpc+2.
REQ-024 Pop SHALL occur when valid_out=1, stall=0 and jump=1; redirect has priority over pop and over stall.
REQ-025 A request SHALL never issue unless (FIFO count + outstanding) < FIFO_DEPTH; push into a full FIFO SHALL be impossible; push and pop on the same edge SHALL keep count unchanged.

Reset
REQ-026 Reset SHALL force: FSM=IDLE, fpc=RESET_PC, FIFO empty, imem_req=0, imem_addr=RESET_PC, valid_out=0, ir_out=16'h0000.
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer; an ack arriving after reset release while IDLE SHALL be ignored.

Configuration
REQ-028 With FETCH_PERF_EN defined: SHALL add outputs perf_fetched (16-bit, +1 per push) and perf_redirects (16-bit, +1 per jump=0 edge), both saturating at 16'hFFFF and cleared by reset.
REQ-029 Without FETCH_PERF_EN: those ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-030 The shared package SHALL hold the FSM state typedef (2-bit), the NOP constant 16'h0000 and the PC increment constant 2.
REQ-031 The prefetch buffer SHALL be a sub-module fetch_fifo (parameterised width 32, depth FIFO_DEPTH, with synchronous flush).

Verification
REQ-032 Reset release with ack tied to 1: imem_addr SHALL be 0000, 0002, 0004 on consecutive cycles, and valid_out=1 with pc_out=0000 two cycles after release.
REQ-033 stall=1 for 5 cycles with ack=1: FIFO fills to 2, imem_req drops, and pc_out is held; on stall=0, order SHALL be preserved with no loss.
REQ-034 jump=0, new_pc=0x0040 while WAIT and ack delayed 3 cycles: state SHALL be DROP, the response SHALL be discarded, and the next imem_addr SHALL be 0x0040.
REQ-035 jump=0 on the same edge as ack (rdata=0xBEEF): 0xBEEF SHALL never appear on ir_out, and imem_addr SHALL be new_pc the next cycle.
REQ-036 Fetch at 0xFFFE: pcp2_out SHALL be 0x0000, and the next imem_addr SHALL be 0x0000.
REQ-037 Reset pulsed mid-WAIT: all outputs SHALL match REQ-026 immediately, without waiting for a clock edge.
